dmem_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port synchronous data memory between REQ_COUNT requesters. Typical requesters are the UART memory interface, the multi-core processor and a debug/readback port. It replaces hard-wired state-based address/data/write-enable muxing. It also returns read data, tagged with a valid pulse, to the requester that issued the read.

---
 rtl/dmem_port_arbiter_pkg.sv | 42 ++++
 rtl/dmem_port_arbiter_if.sv | 32 +++
 rtl/dmem_port_arbiter_picker.sv | 35 +++
 rtl/dmem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared defaults, access-kind encoding and a reference round-robin pick helper
// for the data-memory port arbiter.
package dmem_arb_pkg;

  localparam int unsigned REQ_COUNT_DEF   = 3;
  localparam int unsigned DATA_WIDTH_DEF  = 24;
  localparam int unsigned ADDR_WIDTH_DEF  = 12;
  localparam int unsigned MEM_LATENCY_DEF = 1;
  localparam int unsigned REQ_MAX         = 8;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_kind_e;

  typedef logic [REQ_MAX-1:0] req_vec_t;

  // One-hot winner among the low n bits of req, searching upward from ptr and wrapping.
  function automatic req_vec_t rr_pick(input req_vec_t req, input int unsigned ptr,
                                       input int unsigned n);
    req_vec_t pick;
    logic     found;
    logic [2:0] sel;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < REQ_MAX; k++) begin
      if (k < n) begin
        sel = 3'((ptr + k) % n);
        if (!found && req[sel]) begin
          pick[sel] = 1'b1;
          found     = 1'b1;
        end else begin
          found = found;
        end
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and memory-side signal bundle of dmem_port_arbiter.
// master: requesters plus memory model; slave: the arbiter.
interface dmem_port_arbiter_if import dmem_arb_pkg::*; #(
  parameter int unsigned REQ_COUNT  = REQ_COUNT_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic [REQ_COUNT-1:0]            req;
  logic [REQ_COUNT-1:0]            reqWrEn;
  logic [REQ_COUNT*ADDR_WIDTH-1:0] reqAddr;
  logic [REQ_COUNT*DATA_WIDTH-1:0] reqData;
  logic [REQ_COUNT-1:0]            gnt;
  logic [REQ_COUNT-1:0]            rdValid;
  logic [DATA_WIDTH-1:0]           rdData;
  logic [ADDR_WIDTH-1:0]           memAddr;
  logic [DATA_WIDTH-1:0]           memDataIn;
  logic                            memWrEn;
  logic [DATA_WIDTH-1:0]           memDataOut;
  logic                            busy;

  modport master (
    output req, reqWrEn, reqAddr, reqData, memDataOut,
    input  gnt, rdValid, rdData, memAddr, memDataIn, memWrEn, busy
  );

  modport slave (
    input  req, reqWrEn, reqAddr, reqData, memDataOut,
    output gnt, rdValid, rdData, memAddr, memDataIn, memWrEn, busy
  );

endinterface

// File: rtl/dmem_port_arbiter_picker.sv
// Round-robin priority picker: rotate req down by ptr, find the lowest set bit,
// then rotate the index back into requester numbering.
module rr_priority_picker #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          found
);

  logic [N-1:0]  rot_s;
  logic [PW-1:0] off_s;
  logic [PW:0]   sum_s;

  // Offset of the first requester at or after ptr, mapped back to an absolute index.
  always_comb begin
    rot_s = N'({req, req} >> ptr);
    found = |rot_s;
    off_s = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off_s = PW'(k);
      end else begin
        off_s = off_s;
      end
    end
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    idx   = (sum_s >= (PW+1)'(N)) ? PW'(sum_s - (PW+1)'(N)) : sum_s[PW-1:0];
    gnt   = found ? (N'(1'b1) << idx) : '0;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory between
// REQ_COUNT requesters, returning tagged read data. DMEM_ARB_LOCK_EN adds burst lock.
module dmem_port_arbiter import dmem_arb_pkg::*; #(
  parameter int unsigned REQ_COUNT   = REQ_COUNT_DEF,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 rstN,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [REQ_COUNT-1:0] reqLock,
`endif
  dmem_port_arbiter_if.slave   bus
);

  localparam int unsigned PW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  typedef logic [REQ_COUNT-1:0] onehot_t;

  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  onehot_t               tag_q [MEM_LATENCY];
  onehot_t               tag_d [MEM_LATENCY];
  onehot_t               rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  onehot_t               pick_gnt_s;
  logic [PW-1:0]         pick_idx_s;
  logic                  pick_found_s;
  logic                  win_vld_s;
  logic [PW-1:0]         win_idx_s;
  onehot_t               gnt_s;
  onehot_t               tag_in_s;
  logic                  tag_busy_s;
  logic                  lock_hit_s;

  rr_priority_picker #(
    .N  (REQ_COUNT),
    .PW (PW)
  ) u_picker (
    .req   (bus.req),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

`ifdef DMEM_ARB_LOCK_EN
  logic          lock_vld_q, lock_vld_d;
  logic [PW-1:0] lock_idx_q, lock_idx_d;

  assign lock_hit_s = lock_vld_q && bus.req[lock_idx_q] && reqLock[lock_idx_q];

  // Lock is armed by any grant whose owner holds reqLock, including the first one.
  always_comb begin
    lock_vld_d = win_vld_s && reqLock[win_idx_s];
    lock_idx_d = win_vld_s ? win_idx_s : lock_idx_q;
  end

  // Lock owner registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  assign lock_hit_s = 1'b0;
`endif

  // Winner selection; a live lock overrides the round-robin pick, reset forces no grant.
  always_comb begin
    win_vld_s = 1'b0;
    win_idx_s = '0;
    gnt_s     = '0;
    if (!rstN) begin
      win_vld_s = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    end else if (lock_hit_s) begin
      win_vld_s = 1'b1;
      win_idx_s = lock_idx_q;
      gnt_s     = onehot_t'(1'b1) << lock_idx_q;
`endif
    end else if (pick_found_s) begin
      win_vld_s = 1'b1;
      win_idx_s = pick_idx_s;
      gnt_s     = pick_gnt_s;
    end else begin
      win_vld_s = 1'b0;
    end
  end

  // Memory-side mux from the winning requester's slice.
  always_comb begin
    bus.memAddr   = '0;
    bus.memDataIn = '0;
    bus.memWrEn   = 1'b0;
    if (win_vld_s) begin
      bus.memAddr   = bus.reqAddr[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
      bus.memDataIn = bus.reqData[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
      bus.memWrEn   = bus.reqWrEn[win_idx_s];
    end else begin
      bus.memWrEn   = 1'b0;
    end
  end

  // Next pointer, read-tag shift and read-return capture.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (win_vld_s) begin
      rr_ptr_d = (win_idx_s == PW'(REQ_COUNT - 1)) ? '0 : win_idx_s + PW'(1'b1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    tag_in_s   = (win_vld_s && (bus.reqWrEn[win_idx_s] == ACC_READ)) ? gnt_s : '0;
    tag_d[0]   = tag_in_s;
    for (int k = 1; k < int'(MEM_LATENCY); k++) begin
      tag_d[k] = tag_q[k-1];
    end
    tag_busy_s = 1'b0;
    for (int k = 0; k < int'(MEM_LATENCY); k++) begin
      tag_busy_s = tag_busy_s | (|tag_q[k]);
    end
    rd_valid_d = tag_q[MEM_LATENCY-1];
    rd_data_d  = (|tag_q[MEM_LATENCY-1]) ? bus.memDataOut : rd_data_q;
  end

  // Pointer, tag pipeline and read-return registers; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rr_ptr_q   <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      for (int k = 0; k < int'(MEM_LATENCY); k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      for (int k = 0; k < int'(MEM_LATENCY); k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign bus.gnt     = gnt_s;
  assign bus.rdValid = rd_valid_q;
  assign bus.rdData  = rd_data_q;
  assign bus.busy    = (|gnt_s) | tag_busy_s;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench: two arbiters (memory latency 1 and 2) share one stimulus stream,
// each with its own synchronous memory model.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

  localparam int N  = 3;
  localparam int DW = 24;
  localparam int AW = 12;

  typedef struct {
    int            due;
    logic [N-1:0]  tag;
    logic [DW-1:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req, wr;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] data;
`ifdef DMEM_ARB_LOCK_EN
  logic [N-1:0]    lock;
  logic            m_lock_vld;
  int              m_lock_idx;
`endif

  dmem_port_arbiter_if #(.REQ_COUNT(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  dmem_port_arbiter_if #(.REQ_COUNT(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  assign bus1.req = req;  assign bus1.reqWrEn = wr;  assign bus1.reqAddr = addr;  assign bus1.reqData = data;
  assign bus2.req = req;  assign bus2.reqWrEn = wr;  assign bus2.reqAddr = addr;  assign bus2.reqData = data;

  dmem_port_arbiter #(.REQ_COUNT(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(1)) dut1 (
    .clk (clk), .rstN (rstN),
`ifdef DMEM_ARB_LOCK_EN
    .reqLock (lock),
`endif
    .bus (bus1.slave)
  );

  dmem_port_arbiter #(.REQ_COUNT(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(2)) dut2 (
    .clk (clk), .rstN (rstN),
`ifdef DMEM_ARB_LOCK_EN
    .reqLock (lock),
`endif
    .bus (bus2.slave)
  );

  function automatic logic [DW-1:0] pat(input int a);
    logic [AW-1:0] aa;
    aa = AW'(a);
    return (aa == 12'h005) ? 24'hABC123 : {12'h5A5, aa};
  endfunction

  // Memory models, preloaded on the first edge.
  logic [DW-1:0] mem1 [4096];
  logic [DW-1:0] mem2 [4096];
  logic [DW-1:0] rd1, rd2a, rd2b;
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) begin
        mem1[i] <= pat(i);
        mem2[i] <= pat(i);
      end
      mem_init <= 1'b1;
    end else begin
      if (bus1.memWrEn) mem1[bus1.memAddr] <= bus1.memDataIn;
      if (bus2.memWrEn) mem2[bus2.memAddr] <= bus2.memDataIn;
    end
    rd1  <= mem1[bus1.memAddr];
    rd2a <= mem2[bus2.memAddr];
    rd2b <= rd2a;
  end
  assign bus1.memDataOut = rd1;
  assign bus2.memDataOut = rd2b;

  // Bench model state
  logic [DW-1:0] shadow [4096];
  sb_t           sbq [2][$];
  int            m_ptr;
  int            cyc;
  logic          exp_found;
  int            exp_w;
  int            n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r;
    wr[i]  = w;
    addr[i*AW +: AW] = a;
    data[i*DW +: DW] = d;
  endtask

  task automatic check_cycle();
    logic [N-1:0]  exp_gnt, obs_v [2];
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din, obs_d [2];
    logic          exp_we, inflight;
    exp_found = 1'b0;
    exp_w     = 0;
    if (rstN) begin
`ifdef DMEM_ARB_LOCK_EN
      if (m_lock_vld && req[m_lock_idx] && lock[m_lock_idx]) begin
        exp_found = 1'b1;
        exp_w     = m_lock_idx;
      end
`endif
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!exp_found && req[j]) begin
          exp_found = 1'b1;
          exp_w     = j;
        end
      end
    end
    exp_gnt  = exp_found ? (3'b001 << exp_w) : 3'b000;
    exp_addr = exp_found ? addr[exp_w*AW +: AW] : 12'h000;
    exp_din  = exp_found ? data[exp_w*DW +: DW] : 24'h000000;
    exp_we   = exp_found ? wr[exp_w] : 1'b0;
    chk("gnt_l1", bus1.gnt, exp_gnt);        chk("gnt_l2", bus2.gnt, exp_gnt);
    chk("addr_l1", bus1.memAddr, exp_addr);  chk("addr_l2", bus2.memAddr, exp_addr);
    chk("din_l1", bus1.memDataIn, exp_din);  chk("din_l2", bus2.memDataIn, exp_din);
    chk("we_l1", bus1.memWrEn, exp_we);      chk("we_l2", bus2.memWrEn, exp_we);
    obs_v[0] = bus1.rdValid;  obs_v[1] = bus2.rdValid;
    obs_d[0] = bus1.rdData;   obs_d[1] = bus2.rdData;
    for (int u = 0; u < 2; u++) begin
      inflight = 1'b0;
      foreach (sbq[u][e]) if (sbq[u][e].due > cyc) inflight = 1'b1;
      chk($sformatf("busy_l%0d", u + 1), (u == 0) ? bus1.busy : bus2.busy, exp_found | inflight);
      if (sbq[u].size() > 0 && sbq[u][0].due == cyc) begin
        chk($sformatf("rdvalid_l%0d", u + 1), obs_v[u], sbq[u][0].tag);
        chk($sformatf("rddata_l%0d", u + 1), obs_d[u], sbq[u][0].data);
        void'(sbq[u].pop_front());
      end else begin
        chk($sformatf("rdvalid_idle_l%0d", u + 1), obs_v[u], 3'b000);
      end
    end
  endtask

  task automatic advance_model();
    sb_t e;
    if (!rstN) begin
      m_ptr = 0;
      sbq[0].delete();
      sbq[1].delete();
`ifdef DMEM_ARB_LOCK_EN
      m_lock_vld = 1'b0;
`endif
    end else begin
      if (exp_found) begin
        m_ptr = (exp_w + 1) % N;
        if (wr[exp_w]) begin
          shadow[addr[exp_w*AW +: AW]] = data[exp_w*DW +: DW];
        end else begin
          e.tag  = 3'b001 << exp_w;
          e.data = shadow[addr[exp_w*AW +: AW]];
          e.due  = cyc + 2;  sbq[0].push_back(e);
          e.due  = cyc + 3;  sbq[1].push_back(e);
        end
      end
`ifdef DMEM_ARB_LOCK_EN
      m_lock_vld = exp_found && lock[exp_w];
      m_lock_idx = exp_w;
`endif
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      advance_model();
      cyc++;
      #1;
    end
  endtask

  initial begin
    n_vec = 0;  n_err = 0;  cyc = 0;  m_ptr = 0;
    for (int i = 0; i < 4096; i++) shadow[i] = pat(i);
`ifdef DMEM_ARB_LOCK_EN
    lock = '0;  m_lock_vld = 1'b0;  m_lock_idx = 0;
`endif
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(12'h100 + i), 24'h000000);

    // Reset held with all requests up: no grant, no write, no read return.
    cycle(3);
    rstN = 1'b1;

    // Pure rotation with all requesters reading; then drain.
    cycle(6);
    req = '0;
    cycle(4);

    // Single read of a known word by requester 1.
    set_req(1, 1'b1, 1'b0, 12'h005, 24'h000000);
    cycle(1);
    req = '0;
    cycle(4);

    // Write by requester 0, then read-back by requester 2.
    set_req(0, 1'b1, 1'b1, 12'h010, 24'h000777);
    cycle(1);
    req = '0;
    set_req(2, 1'b1, 1'b0, 12'h010, 24'h000000);
    cycle(1);
    req = '0;
    cycle(4);

    // Random mixed traffic over a small address window.
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < N; r++)
        set_req(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 7)), DW'($urandom));
`ifdef DMEM_ARB_LOCK_EN
      lock = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
`endif
      cycle(1);
    end
    req = '0;
`ifdef DMEM_ARB_LOCK_EN
    lock = '0;
`endif
    cycle(4);

    // Read granted, then asynchronous reset before its data returns.
    set_req(1, 1'b1, 1'b0, 12'h005, 24'h000000);
    cycle(1);
    req = '0;
    rstN = 1'b0;
    sbq[0].delete();
    sbq[1].delete();
    m_ptr = 0;
    cycle(2);
    rstN = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(12'h020 + i), 24'h000000);
`ifdef DMEM_ARB_LOCK_EN
    // Requester 0 locks for four cycles, then releases.
    lock = 3'b001;
    cycle(4);
    lock = 3'b000;
    cycle(3);
`else
    cycle(4);
`endif
    req = '0;
    cycle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
